// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, LFSR taps and traffic-generator FSM states.
package noc_pkg;

    localparam int unsigned DEST_MSB = 31;
    localparam int unsigned DEST_LSB = 24;
    localparam int unsigned SEQ_W    = 24;

    // Fibonacci taps 16,14,13,11 as a mask over value bits [15],[13],[12],[10].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        StWait,
        StSend,
        StGap,
        StDone
    } pe_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pe_traffic_gen_if.sv
// Flit bus between a processing element and the network: RX sink side and TX source side.
interface pe_traffic_gen_if;

    logic [31:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;

    modport master (
        input  i_data,
        input  i_data_valid,
        input  i_data_ready,
        output o_data_ready,
        output o_data,
        output o_data_valid
    );

    modport slave (
        output i_data,
        output i_data_valid,
        output i_data_ready,
        input  o_data_ready,
        input  o_data,
        input  o_data_valid
    );

endinterface

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR, reloaded with the seed on reset, stepped on advance.
module noc_lfsr16
    import noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= seed;
        end else if (advance) begin
            value_q <= lfsr_next(value_q);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pe_traffic_gen.sv
// Per-node traffic generator: injects PKT_LIMIT pseudo-randomly addressed flits and
// counts received and misrouted flits.
module pe_traffic_gen
    import noc_pkg::*;
#(
    parameter int unsigned ADDRESS     = 0,
    parameter int unsigned NUM_PE      = 16,
    parameter int unsigned PKT_LIMIT   = 100,
    parameter int unsigned START_DELAY = 12,
    parameter int unsigned INJ_GAP     = 0,
    parameter int unsigned SKIP_SELF   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    pe_traffic_gen_if.master       bus,
    output logic [15:0]            o_tx_count,
    output logic [15:0]            o_rx_count,
    output logic [15:0]            o_rx_misroute,
    output logic                   o_tx_done
);

    localparam logic [15:0] SEED      = 16'(ADDRESS + 1);
    localparam logic [15:0] DEST_MASK = 16'(NUM_PE - 1);
    localparam logic [7:0]  SELF      = 8'(ADDRESS);
    localparam logic [7:0]  SELF_NEXT = 8'((ADDRESS + 1) % NUM_PE);
    localparam logic [31:0] SEQ_BASE  = 32'(PKT_LIMIT * ADDRESS);

    pe_state_e   state_q;
    logic [31:0] cnt_q;
    logic [31:0] data_q;
    logic        valid_q;
    logic [15:0] tx_count_q;
    logic        done_q;
    logic [15:0] rx_count_q;
    logic [15:0] misroute_q;
    logic [15:0] lfsr_val;
    logic [15:0] tx_count_inc;
    logic        xfer;

    function automatic logic [31:0] make_flit(input logic [15:0] lfsr, input logic [15:0] count);
        logic [7:0]  dest;
        logic [31:0] seq;
        dest = 8'(lfsr & DEST_MASK);
        if (SKIP_SELF != 0 && dest == SELF) dest = SELF_NEXT;
        seq = SEQ_BASE + 32'(count);
        return {dest, seq[SEQ_W-1:0]};
    endfunction

    assign xfer         = valid_q && bus.i_data_ready;
    assign tx_count_inc = tx_count_q + 16'd1;

    noc_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .seed    (SEED),
        .advance (xfer),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StWait;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            tx_count_q <= '0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StWait: begin
                    if (cnt_q == 32'(START_DELAY)) begin
                        state_q <= StSend;
                        valid_q <= 1'b1;
                        data_q  <= make_flit(lfsr_val, tx_count_q);
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StSend: begin
                    if (xfer) begin
                        tx_count_q <= tx_count_inc;
                        if (tx_count_inc == 16'(PKT_LIMIT)) begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (INJ_GAP != 0) begin
                            state_q <= StGap;
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            // LFSR steps on this same edge, so build from its successor.
                            data_q <= make_flit(lfsr_next(lfsr_val), tx_count_inc);
                        end
                    end
                end
                StGap: begin
                    if (cnt_q == 32'(INJ_GAP) - 32'd1) begin
                        state_q <= StSend;
                        valid_q <= 1'b1;
                        data_q  <= make_flit(lfsr_val, tx_count_q);
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StDone: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count_q <= '0;
            misroute_q <= '0;
        end else if (bus.i_data_valid) begin
            if (rx_count_q != 16'hFFFF) rx_count_q <= rx_count_q + 16'd1;
            if (bus.i_data[DEST_MSB:DEST_LSB] != SELF && misroute_q != 16'hFFFF) begin
                misroute_q <= misroute_q + 16'd1;
            end
        end
    end

    assign bus.o_data_ready = 1'b1;
    assign bus.o_data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign o_tx_count       = tx_count_q;
    assign o_rx_count       = rx_count_q;
    assign o_rx_misroute    = misroute_q;
    assign o_tx_done        = done_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Directed bench: three generators (back-to-back, gapped, skip-self) on a shared clock/reset.
module tb_pe_traffic_gen;

    logic clk;
    logic rst;

    pe_traffic_gen_if bus_a ();
    pe_traffic_gen_if bus_b ();
    pe_traffic_gen_if bus_c ();

    logic [15:0] tx_a, rx_a, mis_a, tx_b, rx_b, mis_b, tx_c, rx_c, mis_c;
    logic        done_a, done_b, done_c;

    int n_cmp;
    int n_fail;
    int cyc;
    logic hist_b [0:63];
    logic [31:0] exp_a [0:3];

    pe_traffic_gen #(
        .ADDRESS(3), .NUM_PE(16), .PKT_LIMIT(4), .START_DELAY(12), .INJ_GAP(0), .SKIP_SELF(0)
    ) u_a (
        .clk(clk), .rst(rst), .bus(bus_a), .o_tx_count(tx_a), .o_rx_count(rx_a),
        .o_rx_misroute(mis_a), .o_tx_done(done_a)
    );

    pe_traffic_gen #(
        .ADDRESS(3), .NUM_PE(16), .PKT_LIMIT(4), .START_DELAY(12), .INJ_GAP(2), .SKIP_SELF(0)
    ) u_b (
        .clk(clk), .rst(rst), .bus(bus_b), .o_tx_count(tx_b), .o_rx_count(rx_b),
        .o_rx_misroute(mis_b), .o_tx_done(done_b)
    );

    pe_traffic_gen #(
        .ADDRESS(2), .NUM_PE(4), .PKT_LIMIT(200), .START_DELAY(0), .INJ_GAP(0), .SKIP_SELF(1)
    ) u_c (
        .clk(clk), .rst(rst), .bus(bus_c), .o_tx_count(tx_c), .o_rx_count(rx_c),
        .o_rx_misroute(mis_c), .o_tx_done(done_c)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cyc < 64) hist_b[cyc] = bus_b.o_data_valid;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_data"}, 64'(bus_a.o_data), 64'h0);
        check({tag, "_valid"}, 64'(bus_a.o_data_valid), 64'h0);
        check({tag, "_tx"}, 64'(tx_a), 64'h0);
        check({tag, "_rx"}, 64'(rx_a), 64'h0);
        check({tag, "_mis"}, 64'(mis_a), 64'h0);
        check({tag, "_done"}, 64'(done_a), 64'h0);
    endtask

    initial begin
        logic [15:0] lf;
        logic [7:0]  d;
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        exp_a[0] = 32'h0400_000C;
        exp_a[1] = 32'h0800_000D;
        exp_a[2] = 32'h0000_000E;
        exp_a[3] = 32'h0000_000F;
        bus_a.i_data = '0; bus_a.i_data_valid = 1'b0; bus_a.i_data_ready = 1'b0;
        bus_b.i_data = '0; bus_b.i_data_valid = 1'b0; bus_b.i_data_ready = 1'b1;
        bus_c.i_data = '0; bus_c.i_data_valid = 1'b0; bus_c.i_data_ready = 1'b0;
        for (int i = 0; i < 64; i++) hist_b[i] = 1'b0;

        #2;
        check_a_zero("reset");
        check("sink_ready", 64'(bus_a.o_data_ready), 64'h1);

        // Start-up delay, then first flit held under back-pressure for 5 cycles.
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("wait_idle", 64'(bus_a.o_data_valid), 64'h0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 64'(bus_a.o_data_valid), 64'h1);
            check("stall_data", 64'(bus_a.o_data), 64'(exp_a[0]));
            check("stall_tx", 64'(tx_a), 64'h0);
        end

        // Back-to-back transfers with RX traffic alongside (one misrouted flit).
        for (int k = 0; k < 4; k++) begin
            step();
            bus_a.i_data_ready = 1'b1;
            bus_a.i_data_valid = 1'b1;
            bus_a.i_data = {(k == 1) ? 8'd5 : 8'd3, 24'hABC000 + 24'(k)};
            check("flit_valid", 64'(bus_a.o_data_valid), 64'h1);
            check("flit_data", 64'(bus_a.o_data), 64'(exp_a[k]));
        end
        step();
        bus_a.i_data_ready = 1'b0;
        bus_a.i_data_valid = 1'b0;
        check("done_valid", 64'(bus_a.o_data_valid), 64'h0);
        check("done_flag", 64'(done_a), 64'h1);
        check("done_tx", 64'(tx_a), 64'd4);
        check("rx_count", 64'(rx_a), 64'd4);
        check("rx_misroute", 64'(mis_a), 64'd1);

        // Gapped generator: valid 1,0,0 repeating from cycle 12, done after the 4th.
        step();
        for (int k = 0; k <= 22; k++) begin
            check("gap_pattern", 64'(hist_b[k]), (k == 12 || k == 15 || k == 18 || k == 21) ? 64'h1 : 64'h0);
        end
        check("gap_done", 64'(done_b), 64'h1);
        check("gap_tx", 64'(tx_b), 64'd4);

        // Asynchronous reset from DONE, then mid-run after two transfers.
        rst = 1'b1;
        #1;
        check_a_zero("rst_done");
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        steps(13);
        bus_a.i_data_ready = 1'b1;
        check("rerun1_data", 64'(bus_a.o_data), 64'(exp_a[0]));
        steps(2);
        check("mid_data", 64'(bus_a.o_data), 64'(exp_a[2]));
        check("mid_tx", 64'(tx_a), 64'd2);
        rst = 1'b1;
        #1;
        check_a_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        steps(13);
        for (int k = 0; k < 4; k++) begin
            check("rerun_valid", 64'(bus_a.o_data_valid), 64'h1);
            check("rerun_data", 64'(bus_a.o_data), 64'(exp_a[k]));
            step();
        end
        check("rerun_done", 64'(done_a), 64'h1);
        check("rerun_tx", 64'(tx_a), 64'd4);

        // Skip-self generator against a reference LFSR, 200 back-to-back flits.
        bus_c.i_data_ready = 1'b1;
        lf = 16'd3;
        for (int k = 0; k < 200; k++) begin
            d = {6'b0, lf[1:0]};
            if (d == 8'd2) d = 8'd3;
            check("skip_flit", {31'b0, bus_c.o_data_valid, bus_c.o_data},
                  {31'b0, 1'b1, d, 24'(400 + k)});
            lf = ref_next(lf);
            step();
        end
        check("skip_done", 64'(done_c), 64'h1);
        check("skip_valid", 64'(bus_c.o_data_valid), 64'h0);
        check("skip_tx", 64'(tx_c), 64'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
